rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 10, meaning ROM data width.
REQ-002 The block SHALL have parameter AW, default 4, meaning ROM address width.
REQ-003 The block SHALL have parameter DEPTH, default 10, meaning number of valid ROM words (addresses 0..DEPTH-1).
REQ-004 The block SHALL use a single clock and a synchronous active-high reset.
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have ports req0/req1, input, 1 each, read request from requester 0/1.
REQ-008 The block SHALL have ports addr0/addr1, input, AW each, requested word address.
REQ-009 The block SHALL have ports gnt0/gnt1, output, 1 each, one-cycle grant pulse.
REQ-010 The block SHALL have ports rvalid0/rvalid1, output, 1 each, one-cycle response-valid pulse.
REQ-011 The block SHALL have ports rdata0/rdata1, output, DW each, response data.
REQ-012 The block SHALL have ports err0/err1, output, 1 each, out-of-range flag, qualified by rvalid.
REQ-013 The block SHALL have port rom_addr, output, AW, address to the shared ROM.
REQ-014 The block SHALL have ports rom_cs and rom_rd_en, output, 1 each, ROM chip select and read enable.
REQ-015 The block SHALL have port rom_data, input, DW, combinational ROM read data.

Function
REQ-016 The FSM SHALL have states IDLE, READ and RESP, all outputs registered.
REQ-017 In IDLE with any req high at an edge, the FSM SHALL go to READ, latch the winner index and its address into rom_addr, and pulse the winner's gnt for one cycle.
REQ-018 Arbitration SHALL be round-robin: on simultaneous req0 and req1 the port not served last wins; a single requester wins unconditionally.
REQ-019 The last-served pointer SHALL update only on a grant.
REQ-020 In READ, rom_cs and rom_rd_en SHALL be high for exactly that cycle when the address is below DEPTH, and low otherwise.
REQ-021 On leaving READ, the block SHALL capture rom_data into the winner's rdata, or 0 if out of range, and go to RESP.
REQ-022 In RESP, the winner's rvalid SHALL be high for exactly one cycle, with its err set when the address is at or above DEPTH; the FSM SHALL then return to IDLE.
REQ-023 Latency SHALL be: req sampled at edge N, gnt high in cycle N..N+1, rvalid high in cycle N+2..N+3; at most one transaction every 3 cycles.
REQ-024 rdata of each port SHALL hold its last value until that port's next response.
REQ-025 Requests SHALL be level-sensitive: a requester holds req and addr until gnt; a req dropped before gnt is withdrawn with no response.
REQ-026 Requests arriving in READ or RESP SHALL NOT be sampled until the FSM is back in IDLE.
REQ-027 gnt0 and gnt1 SHALL never be high together, and likewise rvalid0 and rvalid1.

Reset
REQ-028 While rst is high at an edge, the block SHALL enter IDLE, set the pointer so port 0 wins the next tie, and clear gnt*, rvalid*, err*, rdata*, rom_addr, rom_cs and rom_rd_en to 0.
REQ-029 A reset during READ or RESP SHALL abort the transaction with no rvalid issued afterwards.

Structure
REQ-030 A shared package SHALL hold the state enumeration and the constants DW, AW and DEPTH.
REQ-031 The round-robin selector SHALL be the only sub-module, named rr_arb2.

Verification
REQ-032 Single read: ROM word 3 = 0x2A5, req0 with addr0=3 -> gnt0 one cycle later, rvalid0 two cycles later, rdata0=0x2A5, err0=0.
REQ-033 Tie after reset: req0 and req1 both held -> port 0 served first, then port 1, then port 0, alternating with no starvation.
REQ-034 Out of range: req1 with addr1=12 -> rom_cs stays 0, rvalid1 high, err1=1, rdata1=0.
REQ-035 Reset mid-READ: assert rst in READ -> no rvalid, all outputs 0, next tie goes to port 0.
REQ-036 Withdrawal and back-pressure: req1 raised during port-0 READ then dropped before IDLE -> no gnt1 and no rvalid1.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared constants, FSM state encoding and address-range helper for the
// two-port ROM arbiter.
package rom_arbiter_pkg;

  localparam int unsigned DW    = 10;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when the word address falls inside the populated ROM region.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Requester-side handshake and shared-ROM bus of the arbiter.
// slave is the arbiter's view; master is the requesters/ROM view.
import rom_arbiter_pkg::*;

interface rom_arbiter_if #(
  parameter int unsigned DW = rom_arbiter_pkg::DW,
  parameter int unsigned AW = rom_arbiter_pkg::AW
) ();

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          err0;
  logic          err1;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic          rom_rd_en;
  logic [DW-1:0] rom_data;

  modport slave (
    input  req0, req1, addr0, addr1, rom_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           rom_addr, rom_cs, rom_rd_en
  );

  modport master (
    output req0, req1, addr0, addr1, rom_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
           rom_addr, rom_cs, rom_rd_en
  );

endinterface

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-way round-robin selector: combinational winner plus the
// last-served pointer, which only moves when a grant is taken.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic update_i,
  output logic any_c_o,
  output logic win_c_o
);

  logic last_q;

  // On a tie the port not served last wins; a lone requester always wins.
  always_comb begin
    any_c_o = req0_i | req1_i;
    win_c_o = 1'b0;
    if (req0_i && req1_i) begin
      win_c_o = ~last_q;
    end else if (req1_i) begin
      win_c_o = 1'b1;
    end
  end

  // Reset value 1 lets port 0 take the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (update_i && any_c_o) begin
      last_q <= win_c_o;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two requesters onto one combinational ROM; one read per three
// cycles, IDLE -> READ -> RESP, every output registered.
import rom_arbiter_pkg::*;

module rom_arbiter #(
  parameter int unsigned DW    = rom_arbiter_pkg::DW,
  parameter int unsigned AW    = rom_arbiter_pkg::AW,
  parameter int unsigned DEPTH = rom_arbiter_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  rom_arbiter_if.slave  bus
);

  state_e        state_q;
  logic          win_q;
  logic          oor_q;
  logic          gnt0_q;
  logic          gnt1_q;
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic          err0_q;
  logic          err1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic [AW-1:0] rom_addr_q;
  logic          rom_cs_q;
  logic          rom_rd_en_q;

  logic          any_c;
  logic          win_c;
  logic          take_d;
  logic [AW-1:0] sel_addr_d;
  logic          in_range_d;
  logic [DW-1:0] capture_d;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req0_i   (bus.req0),
    .req1_i   (bus.req1),
    .update_i (take_d),
    .any_c_o  (any_c),
    .win_c_o  (win_c)
  );

  // Requests are only looked at while idle.
  always_comb begin
    take_d     = (state_q == ST_IDLE) && any_c;
    sel_addr_d = win_c ? bus.addr1 : bus.addr0;
    in_range_d = addr_in_range(32'(sel_addr_d), DEPTH);
    capture_d  = oor_q ? '0 : bus.rom_data;
  end

  // Pulse outputs default low every cycle; rdata and rom_addr hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      win_q       <= 1'b0;
      oor_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rom_addr_q  <= '0;
      rom_cs_q    <= 1'b0;
      rom_rd_en_q <= 1'b0;
    end else begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rom_cs_q    <= 1'b0;
      rom_rd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_d) begin
            state_q     <= ST_READ;
            win_q       <= win_c;
            oor_q       <= ~in_range_d;
            rom_addr_q  <= sel_addr_d;
            rom_cs_q    <= in_range_d;
            rom_rd_en_q <= in_range_d;
            gnt0_q      <= ~win_c;
            gnt1_q      <= win_c;
          end
        end
        ST_READ: begin
          if (win_q) begin
            rdata1_q <= capture_d;
          end else begin
            rdata0_q <= capture_d;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          rvalid0_q <= ~win_q;
          rvalid1_q <= win_q;
          err0_q    <= ~win_q & oor_q;
          err1_q    <= win_q & oor_q;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rom_cs    = rom_cs_q;
  assign bus.rom_rd_en = rom_rd_en_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: stimulus queues expected grants and
// responses, a negedge monitor pops and compares them as the DUT emits them.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_arbiter_if bus ();

  rom_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    case (a)
      4'd0:    return 10'h011;
      4'd1:    return 10'h0C3;
      4'd2:    return 10'h155;
      4'd3:    return 10'h2A5;
      4'd4:    return 10'h3F0;
      4'd5:    return 10'h07E;
      4'd6:    return 10'h1B2;
      4'd7:    return 10'h246;
      4'd8:    return 10'h333;
      4'd9:    return 10'h0F9;
      default: return 10'h3FF;
    endcase
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  typedef struct {
    logic          port;
    logic [AW-1:0] addr;
    logic          cs;
  } gnt_t;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   errors = 0;
  int   checks = 0;
  int   gnt_age = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_gnt(input logic port, input logic [AW-1:0] addr, input logic cs);
    gnt_t g;
    g.port = port;
    g.addr = addr;
    g.cs   = cs;
    gq.push_back(g);
  endtask

  task automatic push_rsp(input logic port, input logic [DW-1:0] data, input logic err);
    rsp_t r;
    r.port = port;
    r.data = data;
    r.err  = err;
    rq.push_back(r);
  endtask

  // Monitor: every gnt/rvalid pulse must match the head of its queue.
  initial begin : monitor
    gnt_t ge;
    rsp_t re;
    forever begin
      @(negedge clk);
      gnt_age++;
      if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
        gnt_age = 0;
        chk("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL gnt_unexpected: gnt0=%b gnt1=%b with no grant pending", bus.gnt0, bus.gnt1);
        end else begin
          ge = gq.pop_front();
          chk("gnt_port", 32'(bus.gnt1), 32'(ge.port));
          chk("rom_addr", 32'(bus.rom_addr), 32'(ge.addr));
          chk("rom_cs", 32'(bus.rom_cs), 32'(ge.cs));
          chk("rom_rd_en", 32'(bus.rom_rd_en), 32'(ge.cs));
        end
      end
      if (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1) begin
        chk("rvalid_onehot", 32'(bus.rvalid0 & bus.rvalid1), 32'd0);
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: rvalid0=%b rvalid1=%b with no response pending", bus.rvalid0, bus.rvalid1);
        end else begin
          re = rq.pop_front();
          chk("rsp_port", 32'(bus.rvalid1), 32'(re.port));
          chk("rsp_latency", 32'(gnt_age), 32'd2);
          if (re.port) begin
            chk("rdata1", 32'(bus.rdata1), 32'(re.data));
            chk("err1", 32'(bus.err1), 32'(re.err));
          end else begin
            chk("rdata0", 32'(bus.rdata0), 32'(re.data));
            chk("err0", 32'(bus.err0), 32'(re.err));
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_gnt0"},      32'(bus.gnt0), 32'd0);
    chk({tag, "_gnt1"},      32'(bus.gnt1), 32'd0);
    chk({tag, "_rvalid0"},   32'(bus.rvalid0), 32'd0);
    chk({tag, "_rvalid1"},   32'(bus.rvalid1), 32'd0);
    chk({tag, "_err0"},      32'(bus.err0), 32'd0);
    chk({tag, "_err1"},      32'(bus.err1), 32'd0);
    chk({tag, "_rdata0"},    32'(bus.rdata0), 32'd0);
    chk({tag, "_rdata1"},    32'(bus.rdata1), 32'd0);
    chk({tag, "_rom_addr"},  32'(bus.rom_addr), 32'd0);
    chk({tag, "_rom_cs"},    32'(bus.rom_cs), 32'd0);
    chk({tag, "_rom_rd_en"}, 32'(bus.rom_rd_en), 32'd0);
  endtask

  task automatic drive_req(input logic port, input logic val, input logic [AW-1:0] addr);
    if (port) begin
      bus.req1  = val;
      bus.addr1 = addr;
    end else begin
      bus.req0  = val;
      bus.addr0 = addr;
    end
  endtask

  // Waits (bounded) for the given port's grant; returns with req still high.
  task automatic wait_gnt(input logic port);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port ? bus.gnt1 : bus.gnt0) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: port %0d got no grant within 20 cycles", port);
    end
  endtask

  task automatic single(input logic port, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic oor);
    push_gnt(port, addr, ~oor);
    push_rsp(port, data, oor);
    @(negedge clk);
    drive_req(port, 1'b1, addr);
    wait_gnt(port);
    drive_req(port, 1'b0, addr);
    repeat (2) @(negedge clk);
  endtask

  // Both requesters held; grants must alternate starting at port 0.
  task automatic tie(input int n, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int got = 0;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) begin
        push_gnt(1'b0, a0, 1'b1);
        push_rsp(1'b0, d0, 1'b0);
      end else begin
        push_gnt(1'b1, a1, 1'b1);
        push_rsp(1'b1, d1, 1'b0);
      end
    end
    @(negedge clk);
    drive_req(1'b0, 1'b1, a0);
    drive_req(1'b1, 1'b1, a1);
    for (int i = 0; i < 12 * n && got < n; i++) begin
      @(negedge clk);
      if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) got++;
    end
    drive_req(1'b0, 1'b0, a0);
    drive_req(1'b1, 1'b0, a1);
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL tie_timeout: saw %0d of %0d grants", got, n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    rst       = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.addr0 = '0;
    bus.addr1 = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tie(3, 4'd1, 4'd5, 10'h0C3, 10'h07E);

    single(1'b0, 4'd3, 10'h2A5, 1'b0);
    single(1'b1, 4'd12, 10'h000, 1'b1);
    chk("rdata0_hold", 32'(bus.rdata0), 32'h2A5);
    single(1'b0, 4'd9, 10'h0F9, 1'b0);
    single(1'b1, 4'd10, 10'h000, 1'b1);
    single(1'b1, 4'd0, 10'h011, 1'b0);

    // Port 1 raises during port 0's READ and withdraws before IDLE.
    push_gnt(1'b0, 4'd2, 1'b1);
    push_rsp(1'b0, 10'h155, 1'b0);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 4'd2);
    wait_gnt(1'b0);
    drive_req(1'b0, 1'b0, 4'd2);
    drive_req(1'b1, 1'b1, 4'd7);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 4'd7);
    repeat (6) @(negedge clk);

    // Reset in READ: grant seen, no response may follow.
    push_gnt(1'b0, 4'd4, 1'b1);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 4'd4);
    wait_gnt(1'b0);
    drive_req(1'b0, 1'b0, 4'd4);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midread");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    tie(2, 4'd6, 4'd8, 10'h1B2, 10'h333);

    repeat (4) @(negedge clk);
    chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
